ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised multiply/divide execution unit for the EX stage, owning the architectural HI/LO registers. Executes MULT/MULTU over a fixed multi-cycle latency and DIV/DIVU with an iterative radix-2 divider. Holds the pipeline through the existing EX stall-request path while busy. Sits beside the combinational ALU, and its HI/LO read result joins the EX write-back mux.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width; legal values are 8..64.
- MUL_LAT, 3: cycles `stallreq_o` is high for a multiply; legal values are 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  an instruction is present in EX this cycle.
- op_i  in  md_op_t  one of MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO.
- oprd1_i  in  WIDTH  rs value (dividend, multiplicand, MT source).
- oprd2_i  in  WIDTH  rt value (divisor, multiplier).
- flush_i  in  1  abort the current EX instruction.
- stallreq_o  out  1  hold the pipeline; reset value 0.
- rdata_o  out  WIDTH  HI for MD_MFHI, LO for MD_MFLO, otherwise 0; reset value 0.
- hi_o, lo_o  out  WIDTH  current HI/LO registers; reset value 0.
- done_o  out  1  one-cycle pulse when HI/LO receive a mul/div result; reset value 0.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - With `valid_i`, no `flush_i`, and op MULT/MULTU: latch the operands, load the counter with MUL_LAT-1, and go to MUL.
  - With op DIV/DIVU: go to DIV, counter = WIDTH.
  - With op MTHI or MTLO: write HI or LO from `oprd1_i` at the edge. No stall, state stays IDLE.
- `stallreq_o` rules:
  - High combinationally in IDLE when a MULT/MULTU/DIV/DIVU op is accepted.
  - High throughout MUL and DIV.
  - Low in DONE.
  - Forced low in any cycle where `flush_i` is high.
- MUL: decrement the counter each cycle. At 0, write {HI,LO} = the 2·WIDTH-bit product (signed for MULT, unsigned for MULTU), pulse `done_o`, and go to DONE.
- DIV:
  - The first cycle takes absolute values (signed op only).
  - WIDTH restoring iterations follow.
  - The last cycle applies signs and writes LO = quotient, HI = remainder. It pulses `done_o` and goes to DONE.
- DONE: the pipeline advances on this edge. Go to IDLE unconditionally; the still-present op is not re-accepted.
- Signed division: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero (either op): LO = all ones, HI = dividend. Same cycle count as a normal divide.
- DIV of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1), HI = 0.
- `flush_i` in MUL/DIV: go to IDLE at the next edge. HI/LO are unchanged and `done_o` is not pulsed.
- `rdata_o` is combinational from the HI/LO registers, with no bypass. An MF following a mul/div reads the committed value because of the DONE-cycle ordering.
- Reset asserted mid-operation: state → IDLE, HI/LO → 0, and every output goes to its reset value immediately.

## Timing
- Multiply: `stallreq_o` high for MUL_LAT cycles (accept cycle included), then one DONE cycle. EX occupancy is MUL_LAT+1 cycles.
- Divide: `stallreq_o` high for WIDTH+2 cycles (accept cycle, abs, WIDTH iterations), then DONE. EX occupancy is WIDTH+3 cycles.
- HI/LO update on the edge that enters DONE. `done_o` is high during the DONE cycle.
- MT write: visible on `hi_o`/`lo_o` the cycle after the instruction is in EX.

## Configuration
- MULDIV_DIV_EN defined: the divider is built.
- MULDIV_DIV_EN undefined:
  - The divider sub-module is not instantiated.
  - DIV/DIVU complete in one cycle with no stall.
  - HI/LO are unchanged and `done_o` stays low.
  - The DIV state is unreachable.

## Structure
- In project_types:
  - `md_op_t` enum.
  - `md_state_t` enum.
  - Constants MD_DIV_ZERO_LO (all ones) and MUL_LAT_MAX = 8.
- Sub-module `md_div_iter`:
  - Iterative restoring divider.
  - Parametrised by WIDTH.
  - start/busy/done handshake.
  - Compiled only under MULDIV_DIV_EN.
- The multiplier is a behavioural product followed by a delay-counter model in the top level.

## Test plan
- MULT 0xFFFFFFFE × 3 (WIDTH=32, MUL_LAT=3) → `stallreq_o` high 3 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done_o` pulses once.
- DIV −7 / 2 → `stallreq_o` high 34 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/2 → LO=3, HI=1.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI 0x1234, then MFHI the next instruction → `rdata_o`=0x1234 with no stall cycles.
- `flush_i` on the 10th DIV cycle → IDLE at the next edge, HI/LO keep their prior values, no `done_o`. A following MULT is accepted normally.
- Reset pulse mid-MUL → `stallreq_o`, HI, LO and `done_o` are 0 immediately; after release, the next op starts from IDLE.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package project_types;

    // Multiply/divide unit operation codes.
    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    // Top-level sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Divider internal phases.
    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_ABS  = 2'd1,
        DV_ITER = 2'd2
    } dv_phase_t;

    localparam int unsigned WIDTH_MAX   = 64;
    localparam int unsigned MUL_LAT_MAX = 8;
    localparam int unsigned MUL_CNT_W   = $clog2(MUL_LAT_MAX + 1);

    // Quotient reported for a zero divisor; truncated to WIDTH at the use site.
    localparam logic [WIDTH_MAX-1:0] MD_DIV_ZERO_LO = '1;

    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Iterative radix-2 restoring divider: one abs cycle, then WIDTH shift/subtract
// steps. The signed/zero-corrected result is presented combinationally in the
// last step so the caller can commit it on the same edge.
// Built only when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module md_div_iter
    import project_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic             busy_o,
    output logic             done_c_o,
    output logic [WIDTH-1:0] quo_c_o,
    output logic [WIDTH-1:0] rem_c_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    dv_phase_t        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    // Divider state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= DV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_n   = ge ? WIDTH'(diff) : WIDTH'(shifted);
        quo_n   = {quo_q[WIDTH-2:0], ge};
    end

    // Phase sequencing and datapath next-state.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        if (abort_i) begin
            phase_d = DV_IDLE;
        end else begin
            case (phase_q)
                DV_IDLE: begin
                    if (start_i) begin
                        dvd_d   = dvd_i;
                        dvs_d   = dvs_i;
                        sgn_d   = sgn_i;
                        phase_d = DV_ABS;
                    end
                end
                DV_ABS: begin
                    quo_d   = (sgn_q & dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                    dvs_d   = (sgn_q & dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    rem_d   = '0;
                    negq_d  = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    negr_d  = sgn_q & dvd_q[WIDTH-1];
                    zero_d  = (dvs_q == '0);
                    cnt_d   = CNT_W'(WIDTH);
                    phase_d = DV_ITER;
                end
                DV_ITER: begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        phase_d = DV_IDLE;
                    end
                end
                default: phase_d = DV_IDLE;
            endcase
        end
    end

    // Final result: sign correction, zero-divisor override, handshake.
    always_comb begin
        busy_o   = (phase_q != DV_IDLE);
        done_c_o = (phase_q == DV_ITER) && (cnt_q == CNT_W'(1)) && !abort_i;
        quo_c_o  = zero_q ? WIDTH'(MD_DIV_ZERO_LO) : (negq_q ? -quo_n : quo_n);
        rem_c_o  = zero_q ? dvd_q : (negr_q ? -rem_n : rem_n);
    end

endmodule
`endif

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO. Multiplies use a behavioural
// product behind a MUL_LAT delay counter; divides use md_div_iter when
// MULDIV_DIV_EN is defined, otherwise DIV/DIVU retire as no-ops.
module ex_muldiv
    import project_types::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] oprd1_i,
    input  logic [WIDTH-1:0] oprd2_i,
    input  logic             flush_i,
    output logic             stallreq_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o
);

    md_state_t            state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 sgn_q, sgn_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 go_c;
    logic                 accept_mul_c;
    logic                 accept_div_c;
    logic                 stall_c;
    logic [WIDTH-1:0]     mul_a_c, mul_b_c;
    logic                 mul_s_c;
    logic [2*WIDTH-1:0]   prod_c;

    // Sign- or zero-extend to 2*WIDTH so one unsigned multiply covers both forms.
    function automatic logic [2*WIDTH-1:0] mul_ext(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             s);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{s & a[WIDTH-1]}}, a};
        eb = {{WIDTH{s & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    assign go_c         = valid_i & ~flush_i;
    assign accept_mul_c = (state_q == ST_IDLE) && go_c && is_mul(op_i);

`ifdef MULDIV_DIV_EN
    logic             div_busy;
    logic             div_done_c;
    logic [WIDTH-1:0] div_quo_c;
    logic [WIDTH-1:0] div_rem_c;

    assign accept_div_c = (state_q == ST_IDLE) && go_c && is_div(op_i);

    md_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept_div_c),
        .abort_i  (flush_i && (state_q == ST_DIV)),
        .sgn_i    (op_i == MD_DIV),
        .dvd_i    (oprd1_i),
        .dvs_i    (oprd2_i),
        .busy_o   (div_busy),
        .done_c_o (div_done_c),
        .quo_c_o  (div_quo_c),
        .rem_c_o  (div_rem_c)
    );
`else
    assign accept_div_c = 1'b0;
`endif

    // Operand source: live inputs on the accept cycle (MUL_LAT==1), latched otherwise.
    always_comb begin
        mul_a_c = opa_q;
        mul_b_c = opb_q;
        mul_s_c = sgn_q;
        if (state_q == ST_IDLE) begin
            mul_a_c = oprd1_i;
            mul_b_c = oprd2_i;
            mul_s_c = (op_i == MD_MULT);
        end
        prod_c = mul_ext(mul_a_c, mul_b_c, mul_s_c);
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state, HI/LO update and stall request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_mul_c) begin
                    stall_c = 1'b1;
                    opa_d   = oprd1_i;
                    opb_d   = oprd2_i;
                    sgn_d   = (op_i == MD_MULT);
                    cnt_d   = MUL_CNT_W'(MUL_LAT - 1);
                    if (MUL_LAT == 1) begin
                        {hi_d, lo_d} = prod_c;
                        done_d       = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else if (accept_div_c) begin
                    stall_c = 1'b1;
                    state_d = ST_DIV;
                end else if (go_c && (op_i == MD_MTHI)) begin
                    hi_d = oprd1_i;
                end else if (go_c && (op_i == MD_MTLO)) begin
                    lo_d = oprd1_i;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - MUL_CNT_W'(1);
                    if (cnt_q == MUL_CNT_W'(1)) begin
                        {hi_d, lo_d} = prod_c;
                        done_d       = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DIV: begin
`ifdef MULDIV_DIV_EN
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (div_done_c) begin
                        hi_d    = div_rem_c;
                        lo_d    = div_quo_c;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (!div_busy) begin
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // HI/LO read port for MFHI/MFLO.
    always_comb begin
        rdata_o = '0;
        if (op_i == MD_MFHI) begin
            rdata_o = hi_q;
        end else if (op_i == MD_MFLO) begin
            rdata_o = lo_q;
        end
    end

    // Stall is suppressed while reset is asserted so every output reads its reset value.
    assign stallreq_o = stall_c & rst;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32, MUL_LAT=3). Divide expectations
// follow whether MULDIV_DIV_EN is defined for the build.
module tb_ex_muldiv;
    import project_types::*;

    localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    md_op_t       op    = MD_NOP;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         stallreq;
    logic [W-1:0] rdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    ex_muldiv #(.WIDTH(W), .MUL_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid),
        .op_i       (op),
        .oprd1_i    (a),
        .oprd2_i    (b),
        .flush_i    (flush),
        .stallreq_o (stallreq),
        .rdata_o    (rdata),
        .hi_o       (hi),
        .lo_o       (lo),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present one instruction until it leaves EX; count stall and done cycles.
    task automatic exec(input md_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int stalls, output int dones);
        bit fin;
        stalls = 0;
        dones  = 0;
        fin    = 1'b0;
        valid  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        for (int k = 0; k < 100 && !fin; k++) begin
            #1;
            if (done) dones++;
            if (!stallreq) fin = 1'b1;
            else stalls++;
            @(posedge clk); #1;
        end
        if (!fin) stalls = -1;
        valid = 1'b0;
        op    = MD_NOP;
        a     = '0;
        b     = '0;
        #1;
        if (done) dones++;
    endtask

    task automatic run(input string tag, input md_op_t o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int e_st, input int e_dn);
        int st;
        int dn;
        exec(o, x, y, st, dn);
        chk({tag, ".stall"}, 64'(st), 64'(e_st));
        chk({tag, ".done"},  64'(dn), 64'(e_dn));
        chk({tag, ".hi"},    64'(hi), 64'(exp_hi));
        chk({tag, ".lo"},    64'(lo), 64'(exp_lo));
    endtask

    // Divide step: HI/LO only change when the divider is built.
    task automatic run_div(input string tag, input md_op_t o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] q, input logic [W-1:0] r);
        if (DIV_ON) begin
            exp_hi = r;
            exp_lo = q;
        end
        run(tag, o, x, y, DIV_ON ? W + 2 : 0, DIV_ON ? 1 : 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.stall", 64'(stallreq), 64'(0));
        chk("rst.hi",    64'(hi),       64'(0));
        chk("rst.lo",    64'(lo),       64'(0));
        chk("rst.done",  64'(done),     64'(0));
        chk("rst.rdata", 64'(rdata),    64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Multiplies
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
        run("mult_neg2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 3, 1);
        exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
        run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1);

        // Divides
        run_div("div_m7_2",   MD_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu_7_2",   MD_DIVU, 32'd7,         32'd2,        32'd3,         32'd1);
        run_div("div_7_m2",   MD_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("divu_5_0",   MD_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5);
        run_div("div_min_m1", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("div_m7_0",   MD_DIV,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9);

        // MT/MF
        exp_hi = 32'h1234;
        run("mthi", MD_MTHI, 32'h1234, 32'h0, 0, 0);
        valid = 1'b1; op = MD_MFHI;
        #1;
        chk("mfhi.rdata", 64'(rdata),    64'(32'h1234));
        chk("mfhi.stall", 64'(stallreq), 64'(0));
        @(posedge clk); #1;
        valid = 1'b0; op = MD_NOP;
        exp_lo = 32'hABCD;
        run("mtlo", MD_MTLO, 32'hABCD, 32'h0, 0, 0);
        valid = 1'b1; op = MD_MFLO;
        #1;
        chk("mflo.rdata", 64'(rdata), 64'(32'hABCD));
        @(posedge clk); #1;
        valid = 1'b0; op = MD_NOP;
        #1;
        chk("nop.rdata", 64'(rdata), 64'(0));
        @(posedge clk); #1;

        // Flush during MUL
        valid = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        chk("mulflush.stall", 64'(stallreq), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0; op = MD_NOP; a = '0; b = '0;
        #1;
        chk("mulflush.done", 64'(done), 64'(0));
        chk("mulflush.hi",   64'(hi),   64'(32'h1234));
        chk("mulflush.lo",   64'(lo),   64'(32'hABCD));
        exp_hi = 32'd0; exp_lo = 32'd35;
        run("mult_5x7", MD_MULT, 32'd5, 32'd7, 3, 1);

        // Flush on the 10th cycle of a divide
        exp_hi = 32'h1111;
        run("mthi2", MD_MTHI, 32'h1111, 32'h0, 0, 0);
        exp_lo = 32'h2222;
        run("mtlo2", MD_MTLO, 32'h2222, 32'h0, 0, 0);
        valid = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        chk("divflush.stall", 64'(stallreq), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0; op = MD_NOP; a = '0; b = '0;
        #1;
        chk("divflush.done", 64'(done), 64'(0));
        chk("divflush.hi",   64'(hi),   64'(32'h1111));
        chk("divflush.lo",   64'(lo),   64'(32'h2222));
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
        run("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 3, 1);

        // Reset pulse mid-MUL
        valid = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst.stall", 64'(stallreq), 64'(0));
        chk("midrst.hi",    64'(hi),       64'(0));
        chk("midrst.lo",    64'(lo),       64'(0));
        chk("midrst.done",  64'(done),     64'(0));
        @(posedge clk); #1;
        valid = 1'b0; op = MD_NOP; a = '0; b = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_hi = 32'd0; exp_lo = 32'd42;
        run("multu_6x7", MD_MULTU, 32'd6, 32'd7, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
